// File: rtl/ysyx_25020047_lsu_ctrl_if.sv
// ysyx_25020047_lsu_ctrl_if: EXU op/result and data-bus request/response bundle of the LSU
//   slave  - LSU side: op and bus response in; op ready, result and bus request out
//   master - environment side (EXU plus memory), directions mirrored
interface ysyx_25020047_lsu_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_load;
    logic                  in_store;
    logic [1:0]            in_size;
    logic                  in_unsigned;
    logic [ADDR_W-1:0]     in_addr;
    logic [DATA_W-1:0]     in_wdata;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_rdata;
    logic                  out_err;
    logic [1:0]            out_err_code;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_we;
    logic [ADDR_W-1:0]     mem_req_addr;
    logic [DATA_W-1:0]     mem_req_wdata;
    logic [DATA_W/8-1:0]   mem_req_wstrb;
    logic                  mem_rsp_valid;
    logic [DATA_W-1:0]     mem_rsp_rdata;
    logic                  mem_rsp_err;
    modport slave (
        input  in_valid, in_load, in_store, in_size, in_unsigned, in_addr, in_wdata, out_ready,
               mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
        output in_ready, out_valid, out_rdata, out_err, out_err_code,
               mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb
    );
    modport master (
        output in_valid, in_load, in_store, in_size, in_unsigned, in_addr, in_wdata, out_ready,
               mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
        input  in_ready, out_valid, out_rdata, out_err, out_err_code,
               mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb
    );
endinterface

// File: rtl/ysyx_25020047_lsu_ctrl.sv
// ysyx_25020047_lsu_ctrl: one-op-in-flight load/store unit between EXU and a valid/ready data bus
//   clk, rst - clock, synchronous active-high reset
//   lsu      - slave view of the EXU op/result and memory request/response bundle
module ysyx_25020047_lsu_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rst,
    ysyx_25020047_lsu_ctrl_if.slave lsu
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
    state_t               r_state, w_next;
    logic [OFF_W-1:0]     r_off;
    logic [1:0]           r_size;
    logic                 r_uns;
    logic                 r_we;
    logic [ADDR_W-1:OFF_W] r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_err;
    logic [1:0]           r_code;
    logic [CNT_W-1:0]     r_cnt;
    logic                 w_accept, w_mis, w_ill, w_hs, w_hit, w_tmo, w_req, w_resp;
    logic [DATA_W-1:0]    w_lane, w_mask, w_sb, w_ext;
    logic [6:0]           w_bits;
    logic [STRB_W-1:0]    w_strb;
    assign w_accept = r_state == S_IDLE && lsu.in_valid;
    assign w_mis    = (lsu.in_size == 2'd1 && lsu.in_addr[0]) ||
                      (lsu.in_size == 2'd2 && lsu.in_addr[1:0] != 2'd0) ||
                      (lsu.in_size == 2'd3 && lsu.in_addr[2:0] != 3'd0);
    assign w_ill    = (lsu.in_load == lsu.in_store) || (lsu.in_size == 2'd3 && DATA_W == 32);
    assign w_hs     = r_state == S_REQ && lsu.mem_req_ready;
    // a response in the handshake cycle counts as an immediate WAIT hit
    assign w_hit    = (w_hs || r_state == S_WAIT) && lsu.mem_rsp_valid;
    assign w_tmo    = r_state == S_WAIT && !lsu.mem_rsp_valid && r_cnt == CNT_W'(TIMEOUT - 1);
    assign w_req    = r_state == S_REQ;
    assign w_resp   = r_state == S_RESP;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (lsu.in_valid) w_next = (w_mis || w_ill) ? S_RESP : S_REQ;
            S_REQ:   if (lsu.mem_req_ready) w_next = lsu.mem_rsp_valid ? S_RESP : S_WAIT;
            S_WAIT:  if (lsu.mem_rsp_valid || w_tmo) w_next = S_RESP;
            default: if (lsu.out_ready) w_next = S_IDLE;
        endcase
    end
    // extension by xor/subtract of the sign bit: field width follows size, no replication needed
    assign w_lane = lsu.mem_rsp_rdata >> {r_off, 3'b000};
    assign w_bits = 7'd8 << r_size;
    assign w_mask = r_size == 2'd3 ? '1 : (DATA_W'(1) << w_bits) - DATA_W'(1);
    assign w_sb   = (r_uns || r_size == 2'd3) ? '0 : DATA_W'(1) << (w_bits - 7'd1);
    assign w_ext  = ((w_lane & w_mask) ^ w_sb) - w_sb;
    assign w_strb = STRB_W'((32'd1 << (32'd1 << r_size)) - 32'd1) << r_off;
    assign lsu.in_ready      = r_state == S_IDLE;
    assign lsu.out_valid     = w_resp;
    assign lsu.out_rdata     = w_resp ? r_rdata : '0;
    assign lsu.out_err       = w_resp && r_err;
    assign lsu.out_err_code  = w_resp ? r_code : 2'b00;
    assign lsu.mem_req_valid = w_req;
    assign lsu.mem_req_we    = w_req && r_we;
    assign lsu.mem_req_addr  = w_req ? {r_addr, OFF_W'(0)} : '0;
    assign lsu.mem_req_wdata = w_req ? r_wdata << {r_off, 3'b000} : '0;
    assign lsu.mem_req_wstrb = (w_req && r_we) ? w_strb : '0;
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_off   <= '0;
            r_size  <= '0;
            r_uns   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_code  <= 2'b00;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_off   <= lsu.in_addr[OFF_W-1:0];
                r_size  <= lsu.in_size;
                r_uns   <= lsu.in_unsigned;
                r_we    <= lsu.in_store;
                r_addr  <= lsu.in_addr[ADDR_W-1:OFF_W];
                r_wdata <= lsu.in_wdata;
                r_rdata <= '0;
                r_err   <= w_mis || w_ill;
                r_code  <= w_mis ? 2'b01 : w_ill ? 2'b11 : 2'b00;
            end
            if (w_hs) r_cnt <= '0;
            else if (r_state == S_WAIT) r_cnt <= r_cnt + CNT_W'(1);
            if (w_hit) begin
                r_rdata <= (r_we || lsu.mem_rsp_err) ? '0 : w_ext;
                r_err   <= lsu.mem_rsp_err;
                r_code  <= lsu.mem_rsp_err ? 2'b10 : 2'b00;
            end else if (w_tmo) begin
                r_err  <= 1'b1;
                r_code <= 2'b11;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_25020047_lsu_ctrl.sv
// tb_ysyx_25020047_lsu_ctrl: directed LSU ops checked against a behavioural model and pinned literals
module tb_ysyx_25020047_lsu_ctrl;
    localparam int TIMEOUT = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    ysyx_25020047_lsu_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus ();
    ysyx_25020047_lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .lsu(bus)
    );
    typedef struct {
        logic        ld;
        logic        st;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          rd;
        int          k;
        logic [31:0] rsp;
        logic        rerr;
        int          hold;
        logic        lit;
        logic [31:0] lit_rdata;
        logic [1:0]  lit_code;
        int          lit_lat;
    } op_t;
    int          checks = 0;
    int          errors = 0;
    logic        exp_bus = 1'b0;
    logic        out_allowed = 1'b0;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_strb;
    logic        e_we, e_err;
    logic [1:0]  e_code;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, want, $time);
        end
    endtask
    function automatic int nbytes(op_t o);
        return 1 << o.size;
    endfunction
    function automatic bit m_fault(op_t o);
        return (o.addr % nbytes(o) != 0) || (o.ld == o.st) || (o.size == 2'd3);
    endfunction
    function automatic logic [1:0] m_code(op_t o);
        if (o.addr % nbytes(o) != 0) return 2'b01;
        if (o.ld == o.st || o.size == 2'd3) return 2'b11;
        if (o.k < 0) return 2'b11;
        if (o.rerr) return 2'b10;
        return 2'b00;
    endfunction
    function automatic logic [31:0] m_rdata(op_t o);
        longint unsigned lane, span, v;
        int off;
        if (m_code(o) != 2'b00 || o.st) return 32'd0;
        off  = int'(o.addr % 4);
        lane = 64'(o.rsp) >> (8 * off);
        span = 64'd1 << (8 * nbytes(o));
        v    = lane % span;
        if (!o.uns && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction
    function automatic int m_lat(op_t o);
        if (m_fault(o)) return 1;
        return 2 + o.rd + (o.k < 0 ? TIMEOUT : o.k);
    endfunction
    function automatic op_t mk(logic ld, logic st, logic [1:0] size, logic uns, logic [31:0] addr,
                               logic [31:0] wdata, int rd, int k, logic [31:0] rsp, logic rerr, int hold);
        op_t o;
        o.ld = ld; o.st = st; o.size = size; o.uns = uns; o.addr = addr; o.wdata = wdata;
        o.rd = rd; o.k = k; o.rsp = rsp; o.rerr = rerr; o.hold = hold;
        o.lit = 1'b0; o.lit_rdata = 32'd0; o.lit_code = 2'b00; o.lit_lat = 0;
        return o;
    endfunction
    function automatic op_t pin(op_t o, logic [31:0] rdata, logic [1:0] code, int lat);
        op_t p = o;
        p.lit = 1'b1; p.lit_rdata = rdata; p.lit_code = code; p.lit_lat = lat;
        return p;
    endfunction
    task automatic idle_inputs();
        bus.in_valid = 1'b0; bus.in_load = 1'b0; bus.in_store = 1'b0; bus.in_size = 2'd0;
        bus.in_unsigned = 1'b0; bus.in_addr = 32'd0; bus.in_wdata = 32'd0; bus.out_ready = 1'b0;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = 32'd0; bus.mem_rsp_err = 1'b0;
    endtask
    task automatic set_exp(op_t o);
        longint unsigned w;
        int off, s;
        off     = int'(o.addr % 4);
        w       = 64'(o.wdata) << (8 * off);
        s       = ((1 << nbytes(o)) - 1) << off;
        exp_bus = !m_fault(o);
        e_addr  = o.addr & 32'hFFFF_FFFC;
        e_we    = o.st;
        e_wdata = w[31:0];
        e_strb  = o.st ? s[3:0] : 4'd0;
        e_code  = m_code(o);
        e_err   = e_code != 2'b00;
        e_rdata = m_rdata(o);
    endtask
    task automatic present(op_t o);
        chk("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1; bus.in_load = o.ld; bus.in_store = o.st; bus.in_size = o.size;
        bus.in_unsigned = o.uns; bus.in_addr = o.addr; bus.in_wdata = o.wdata;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_load = 1'b0; bus.in_store = 1'b0; bus.in_wdata = 32'd0;
    endtask
    task automatic drive_rsp(op_t o);
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = o.rsp; bus.mem_rsp_err = o.rerr;
    endtask
    task automatic run_op(op_t o);
        int t, seen, w;
        bit hs, done;
        set_exp(o);
        out_allowed = 1'b1;
        present(o);
        t = 1; seen = 0; w = 0; hs = 0; done = 0;
        while (!done) begin
            bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = 32'd0; bus.mem_rsp_err = 1'b0;
            if (bus.out_valid) done = 1;
            else if (t > 60) begin
                chk("result_within_budget", 0, 1);
                done = 1;
            end else begin
                if (bus.mem_req_valid) begin
                    if (seen < o.rd) begin
                        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'hFFFF_FFFF; bus.mem_rsp_err = 1'b1;
                    end else begin
                        bus.mem_req_ready = 1'b1;
                        if (o.k == 0) drive_rsp(o);
                        hs = 1;
                    end
                    seen++;
                end else if (hs) begin
                    w++;
                    if (o.k == w) drive_rsp(o);
                end
                @(negedge clk);
                t++;
            end
        end
        chk("latency", t, m_lat(o));
        if (o.lit) begin
            chk("pin_rdata", bus.out_rdata, o.lit_rdata);
            chk("pin_code", bus.out_err_code, o.lit_code);
            chk("pin_latency", t, o.lit_lat);
        end
        for (int h = 0; h < o.hold; h++) begin
            bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'h5A5A_5A5A; bus.mem_rsp_err = 1'b1;
            @(negedge clk);
        end
        bus.mem_rsp_valid = 1'b0; bus.mem_rsp_err = 1'b0; bus.mem_rsp_rdata = 32'd0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        out_allowed = 1'b0;
        exp_bus = 1'b0;
        chk("back_idle_ready", bus.in_ready, 1);
        chk("back_idle_valid", bus.out_valid, 0);
    endtask
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (bus.mem_req_valid) begin
                chk("req_allowed", bus.mem_req_valid, exp_bus);
                if (exp_bus) begin
                    chk("req_addr", bus.mem_req_addr, e_addr);
                    chk("req_we", bus.mem_req_we, e_we);
                    chk("req_wstrb", bus.mem_req_wstrb, e_strb);
                    if (e_we) chk("req_wdata", bus.mem_req_wdata, e_wdata);
                    chk("in_ready_busy", bus.in_ready, 0);
                end
            end
            if (bus.out_valid) begin
                chk("out_allowed", bus.out_valid, out_allowed);
                if (out_allowed) begin
                    chk("out_rdata", bus.out_rdata, e_rdata);
                    chk("out_err", bus.out_err, e_err);
                    chk("out_err_code", bus.out_err_code, e_code);
                    chk("in_ready_resp", bus.in_ready, 0);
                end
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL global_watchdog got running want finished");
        $fatal(1, "watchdog");
    end
    initial begin
        op_t ops[$];
        op_t r;
        ops.push_back(pin(mk(1, 0, 2'd0, 0, 32'h8000_0003, 0, 0, 0, 32'h80FF_1234, 0, 0), 32'hFFFF_FF80, 2'b00, 2));
        ops.push_back(pin(mk(1, 0, 2'd1, 1, 32'h8000_0002, 0, 0, 1, 32'hBEEF_0000, 0, 1), 32'h0000_BEEF, 2'b00, 3));
        ops.push_back(pin(mk(1, 0, 2'd1, 0, 32'h8000_0002, 0, 1, 0, 32'hBEEF_0000, 0, 0), 32'hFFFF_BEEF, 2'b00, 3));
        ops.push_back(pin(mk(0, 1, 2'd1, 0, 32'h8000_0002, 32'h1234_ABCD, 0, 0, 32'hDEAD_BEEF, 0, 0), 32'd0, 2'b00, 2));
        ops.push_back(pin(mk(1, 0, 2'd2, 0, 32'h8000_0001, 0, 0, 0, 32'h1111_1111, 0, 1), 32'd0, 2'b01, 1));
        ops.push_back(pin(mk(1, 0, 2'd2, 0, 32'h8000_0004, 0, 5, 2, 32'h1122_3344, 1, 0), 32'd0, 2'b10, 9));
        ops.push_back(pin(mk(1, 0, 2'd2, 0, 32'h8000_0008, 0, 0, -1, 32'h5566_7788, 0, 3), 32'd0, 2'b11, 6));
        ops.push_back(pin(mk(1, 0, 2'd2, 0, 32'h8000_000C, 0, 0, TIMEOUT, 32'h7FFF_FFFF, 0, 0), 32'h7FFF_FFFF, 2'b00, 6));
        ops.push_back(pin(mk(1, 0, 2'd0, 1, 32'h8000_0001, 0, 0, 0, 32'h0000_AB00, 0, 0), 32'h0000_00AB, 2'b00, 2));
        ops.push_back(pin(mk(1, 0, 2'd0, 0, 32'h8000_0000, 0, 2, 1, 32'h1234_567F, 0, 0), 32'h0000_007F, 2'b00, 5));
        ops.push_back(mk(0, 1, 2'd0, 0, 32'h8000_0003, 32'h0000_00A5, 1, 0, 32'h0, 0, 0));
        ops.push_back(mk(0, 1, 2'd2, 0, 32'h8000_0010, 32'hCAFE_F00D, 0, 3, 32'h0, 0, 2));
        ops.push_back(mk(0, 1, 2'd2, 0, 32'h8000_0014, 32'h0000_0001, 0, 0, 32'h0, 1, 0));
        ops.push_back(pin(mk(1, 1, 2'd2, 0, 32'h8000_0000, 0, 0, 0, 32'h0, 0, 0), 32'd0, 2'b11, 1));
        ops.push_back(mk(0, 0, 2'd0, 0, 32'h8000_0000, 0, 0, 0, 32'h0, 0, 0));
        ops.push_back(pin(mk(1, 0, 2'd3, 0, 32'h8000_0000, 0, 0, 0, 32'h0, 0, 0), 32'd0, 2'b11, 1));
        ops.push_back(mk(1, 0, 2'd1, 0, 32'h8000_0003, 0, 0, 0, 32'h0, 0, 0));
        ops.push_back(mk(0, 1, 2'd1, 0, 32'h8000_0001, 32'hFFFF_FFFF, 0, 0, 32'h0, 0, 0));
        ops.push_back(pin(mk(1, 0, 2'd1, 0, 32'h8000_0000, 0, 0, 0, 32'h1234_8001, 0, 0), 32'hFFFF_8001, 2'b00, 2));
        ops.push_back(mk(0, 1, 2'd0, 0, 32'h8000_0001, 32'h1234_5678, 0, 2, 32'h0, 0, 0));
        ops.push_back(mk(0, 1, 2'd2, 0, 32'h8000_0018, 32'hFFFF_0000, 0, -1, 32'h0, 0, 0));
        ops.push_back(mk(1, 0, 2'd2, 1, 32'h8000_001C, 0, 0, 0, 32'hFFFF_FFFF, 0, 0));
        ops.push_back(pin(mk(1, 0, 2'd0, 1, 32'h8000_0020, 0, 0, 0, 32'h0000_0012, 0, 0), 32'h0000_0012, 2'b00, 2));
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_rdata", bus.out_rdata, 0);
        chk("rst_out_err", {bus.out_err, bus.out_err_code}, 0);
        chk("rst_req_valid", bus.mem_req_valid, 0);
        chk("rst_req_fields", {bus.mem_req_we, bus.mem_req_wstrb, bus.mem_req_addr, bus.mem_req_wdata}, 0);
        rst = 1'b0;
        @(negedge clk);
        foreach (ops[i]) run_op(ops[i]);
        r = mk(1, 0, 2'd2, 0, 32'h8000_0040, 0, 0, -1, 32'h0, 0, 0);
        set_exp(r);
        out_allowed = 1'b0;
        present(r);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_bus = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_in_ready", bus.in_ready, 1);
        chk("rst_mid_req_valid", bus.mem_req_valid, 0);
        chk("rst_mid_out_valid", bus.out_valid, 0);
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'hA5A5_A5A5; bus.mem_rsp_err = 1'b1;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0; bus.mem_rsp_err = 1'b0; bus.mem_rsp_rdata = 32'd0;
        @(negedge clk);
        chk("idle_rsp_ignored_valid", bus.out_valid, 0);
        chk("idle_rsp_ignored_ready", bus.in_ready, 1);
        run_op(ops[0]);
        run_op(ops[1]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
